// File: rtl/pc_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Bundles the two handshakes owned by the fetch controller:
//   imem side  : imem_req_valid/imem_req_ready/imem_addr (request),
//                imem_rsp_valid/imem_rsp_data (in-order response, always accepted)
//   decode side: instr_valid/instr_ready/instr_data/instr_pc (buffer head)
// modport master : the fetch controller
// modport slave  : the environment (imem + decode)
// ----------------------------------------------------------------------------
interface pc_fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
// Owns the PC, issues word fetches to imem under a credit limit, buffers
// returned instructions (with their PC) for decode, and redirects fetch on
// taken branches/jumps while discarding stale in-flight responses.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   bus (master)        imem request/response and decode handshakes
//   i_br_*              branch resolution (valid, branch, jump, funct3, ZF, SF, target)
//   o_flush             one-cycle pulse after a taken redirect
//   o_misalign_err      sticky, set by a taken redirect to a non-word target
// ----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_OUT   = 2,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pc_fetch_ctrl_if.master        bus,
    input  logic                   i_br_valid,
    input  logic                   i_br_branch,
    input  logic                   i_br_jump,
    input  logic [2:0]             i_br_funct3,
    input  logic                   i_br_zf,
    input  logic                   i_br_sf,
    input  logic [31:0]            i_br_target,
    output logic                   o_flush,
    output logic                   o_misalign_err
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int             PW        = (BUF_DEPTH > 2) ? 2 : 1;
    localparam logic [3:0]     MAX_OUT_L = 4'(MAX_OUT);
    localparam logic [3:0]     DEPTH_L   = 4'(BUF_DEPTH);
    localparam logic [PW-1:0]  LAST_IDX  = PW'(BUF_DEPTH - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_rsp_pc;       // PC of the next response that will be kept
    logic [2:0]     r_outstanding;
    logic [2:0]     r_discard;
    logic [2:0]     r_buf_cnt;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [31:0]    r_buf_pc   [BUF_DEPTH];
    logic [31:0]    r_buf_data [BUF_DEPTH];
    logic           r_flush;
    logic           r_misalign_err;

    logic           w_cond;
    logic           w_taken;
    logic           w_redirect;
    logic           w_target_ok;
    logic           w_req_valid;
    logic           w_req_fire;
    logic           w_rsp_fire;
    logic           w_instr_valid;
    logic           w_push;
    logic           w_pop;
    logic [2:0]     w_out_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_IDX) begin
            return '0;
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Branch condition decode and taken/redirect qualification.
    always_comb begin
        w_cond = 1'b0;
        case (i_br_funct3)
            3'b000:  w_cond = i_br_zf;
            3'b001:  w_cond = ~i_br_zf;
            3'b100:  w_cond = i_br_sf;
            3'b101:  w_cond = ~i_br_sf;
            default: w_cond = 1'b0;
        endcase
        w_taken     = i_br_valid & (i_br_jump | (i_br_branch & w_cond));
        // HALT ignores further redirects; only reset leaves it.
        w_redirect  = w_taken & (r_state != ST_HALT);
        w_target_ok = (i_br_target[1:0] == 2'b00);
    end

    // Request credit, handshake fires and buffer push/pop qualification.
    always_comb begin
        w_req_valid = 1'b0;
        // Counting buffered entries as credits guarantees every kept response has a slot.
        if (!i_rst && (r_state == ST_FETCH) && !w_taken &&
            ({1'b0, r_outstanding} < MAX_OUT_L) &&
            (({1'b0, r_outstanding} + {1'b0, r_buf_cnt}) < DEPTH_L)) begin
            w_req_valid = 1'b1;
        end else begin
            w_req_valid = 1'b0;
        end
        w_req_fire    = w_req_valid & bus.imem_req_ready;
        w_rsp_fire    = bus.imem_rsp_valid;
        w_instr_valid = !i_rst && (r_buf_cnt != 3'd0) && !w_taken && (r_state != ST_HALT);
        w_pop         = w_instr_valid & bus.instr_ready;
        w_push        = w_rsp_fire & (r_discard == 3'd0) & (r_state == ST_FETCH) & ~w_taken;
        w_out_nxt     = r_outstanding + {2'b00, w_req_fire} - {2'b00, w_rsp_fire};
    end

    // Next-state logic for FETCH / DRAIN / HALT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH, ST_DRAIN: begin
                if (w_taken) begin
                    if (!w_target_ok) begin
                        w_state_nxt = ST_HALT;
                    end else if (w_out_nxt != 3'd0) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else if ((r_state == ST_DRAIN) && (r_discard == 3'd0)) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, credit counters, buffer pointers and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc     <= RESET_PC;
            r_rsp_pc       <= RESET_PC;
            r_outstanding  <= 3'd0;
            r_discard      <= 3'd0;
            r_buf_cnt      <= 3'd0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_flush        <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_flush       <= w_redirect;
            if (w_redirect) begin
                // Everything still in flight after this cycle is stale.
                r_discard <= w_out_nxt;
                r_buf_cnt <= 3'd0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                if (w_target_ok) begin
                    r_fetch_pc <= i_br_target;
                    r_rsp_pc   <= i_br_target;
                end else begin
                    r_misalign_err <= 1'b1;
                end
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_fire && (r_discard != 3'd0)) begin
                    r_discard <= r_discard - 3'd1;
                end
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                r_buf_cnt <= r_buf_cnt + {2'b00, w_push} - {2'b00, w_pop};
            end
        end
    end

    // Buffer storage; validity is tracked by r_buf_cnt so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
            r_buf_data[r_wr_ptr] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_fetch_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr_pc       = r_buf_pc[r_rd_ptr];
    assign bus.instr_data     = r_buf_data[r_rd_ptr];
    assign o_flush            = r_flush;
    assign o_misalign_err     = r_misalign_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed bench: an in-order imem model with 1-cycle latency (and a hold
// switch to keep requests outstanding) drives dut0 (RESET_PC=0); dut1
// (RESET_PC=0xFFFF_FFF8) runs free to observe address wrap.
// ----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if b0 ();
    pc_fetch_ctrl_if b1 ();

    logic        br_valid, br_branch, br_jump, br_zf, br_sf;
    logic [2:0]  br_funct3;
    logic [31:0] br_target;
    logic        flush0, mis0, flush1, mis1;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_OUT(2), .BUF_DEPTH(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(b0),
        .i_br_valid(br_valid), .i_br_branch(br_branch), .i_br_jump(br_jump),
        .i_br_funct3(br_funct3), .i_br_zf(br_zf), .i_br_sf(br_sf),
        .i_br_target(br_target), .o_flush(flush0), .o_misalign_err(mis0)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .MAX_OUT(2), .BUF_DEPTH(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(b1),
        .i_br_valid(1'b0), .i_br_branch(1'b0), .i_br_jump(1'b0),
        .i_br_funct3(3'b000), .i_br_zf(1'b0), .i_br_sf(1'b0),
        .i_br_target(32'h0000_0000), .o_flush(flush1), .o_misalign_err(mis1)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          flush_cnt = 0;
    bit          hold = 1'b0;
    bit          r1_pend = 1'b0;
    logic [31:0] r1_addr = 32'h0;
    logic [31:0] q_addr [$];
    int          q_cyc [$];
    logic [31:0] req_log [$];
    logic [31:0] pop_pc [$];
    logic [31:0] pop_data [$];
    logic [31:0] req1_log [$];
    logic [7:0]  vec [0:9];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pop_pc_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_data_at(input int i);
        return (i < pop_data.size()) ? pop_data[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] req1_at(input int i);
        return (i < req1_log.size()) ? req1_log[i] : 32'hDEAD_DEAD;
    endfunction

    // One clock cycle: drive responses, sample handshakes, advance to the next negedge.
    task automatic tick();
        if (rst) begin
            q_addr.delete();
            q_cyc.delete();
            r1_pend = 1'b0;
        end
        if (!rst && !hold && (q_addr.size() > 0) && (q_cyc[0] < cyc)) begin
            b0.imem_rsp_valid = 1'b1;
            b0.imem_rsp_data  = memf(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_cyc.pop_front());
        end else begin
            b0.imem_rsp_valid = 1'b0;
            b0.imem_rsp_data  = 32'h0000_0000;
        end
        b1.imem_rsp_valid = r1_pend;
        b1.imem_rsp_data  = memf(r1_addr);
        #1;
        if (b0.imem_req_valid && b0.imem_req_ready) begin
            q_addr.push_back(b0.imem_addr);
            q_cyc.push_back(cyc);
            req_log.push_back(b0.imem_addr);
        end
        if (b0.instr_valid && b0.instr_ready) begin
            pop_pc.push_back(b0.instr_pc);
            pop_data.push_back(b0.instr_data);
        end
        if (flush0) flush_cnt++;
        r1_pend = b1.imem_req_valid && b1.imem_req_ready;
        if (r1_pend) begin
            r1_addr = b1.imem_addr;
            req1_log.push_back(b1.imem_addr);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req_log.delete();
        pop_pc.delete();
        pop_data.delete();
    endtask

    initial begin
        int n;
        logic [7:0] v;
        vec = '{8'b000_0_0_1_0_0, 8'b000_1_0_1_0_1, 8'b001_0_0_1_0_1, 8'b001_1_0_1_0_0,
                8'b100_0_1_1_0_1, 8'b101_0_1_1_0_0, 8'b101_0_0_1_0_1, 8'b010_1_1_1_0_0,
                8'b000_1_0_0_0_0, 8'b011_0_0_0_1_1};
        b0.imem_req_ready = 1'b1; b0.instr_ready = 1'b1;
        b0.imem_rsp_valid = 1'b0; b0.imem_rsp_data = 32'h0;
        b1.imem_req_ready = 1'b1; b1.instr_ready = 1'b1;
        b1.imem_rsp_valid = 1'b0; b1.imem_rsp_data = 32'h0;
        br_valid = 1'b0; br_branch = 1'b0; br_jump = 1'b0; br_zf = 1'b0; br_sf = 1'b0;
        br_funct3 = 3'b000; br_target = 32'h0;

        // Reset state
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rst req_valid", b0.imem_req_valid, 32'd0);
        check_eq("rst instr_valid", b0.instr_valid, 32'd0);
        check_eq("rst flush", flush0, 32'd0);
        check_eq("rst misalign", mis0, 32'd0);
        rst = 1'b0;
        req_log.delete(); pop_pc.delete(); pop_data.delete();
        #1;
        check_eq("first addr", b0.imem_addr, 32'h0000_0000);
        check_eq("first req_valid", b0.imem_req_valid, 32'd1);

        // 1: free-running sequential fetch
        repeat (12) tick();
        for (int i = 0; i < 4; i++) check_eq("seq pc", pop_pc_at(i), 32'(4 * i));
        check_eq("seq data0", pop_data_at(0), memf(32'h0));
        check_eq("seq data3", pop_data_at(3), memf(32'hC));

        // 2: decode stalled, credit limit holds issue at BUF_DEPTH
        b0.instr_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        check_eq("stall req count", 32'(req_log.size()), 32'd2);
        check_eq("stall req1 addr", req_at(1), 32'h4);
        check_eq("stall no pop", 32'(pop_pc.size()), 32'd0);
        #1;
        check_eq("stall req_valid", b0.imem_req_valid, 32'd0);
        check_eq("stall head pc", b0.instr_pc, 32'h0);
        b0.instr_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 3; i++) check_eq("release pc", pop_pc_at(i), 32'(4 * i));
        check_eq("release data2", pop_data_at(2), memf(32'h8));

        // 3: taken BEQ with pc 8 and 12 outstanding
        do_reset();
        hold = 1'b1; repeat (3) tick();
        hold = 1'b0; repeat (3) tick();
        hold = 1'b1; repeat (2) tick();
        check_eq("pre-br req count", 32'(req_log.size()), 32'd4);
        check_eq("pre-br req2", req_at(2), 32'h8);
        check_eq("pre-br req3", req_at(3), 32'hC);
        check_eq("pre-br pops", 32'(pop_pc.size()), 32'd2);
        hold = 1'b0;
        flush_cnt = 0;
        br_valid = 1'b1; br_branch = 1'b1; br_funct3 = 3'b000; br_zf = 1'b1;
        br_target = 32'h0000_0100;
        tick();
        br_valid = 1'b0; br_branch = 1'b0; br_zf = 1'b0;
        #1;
        check_eq("br flush pulse", flush0, 32'd1);
        tick();
        #1;
        check_eq("br flush end", flush0, 32'd0);
        repeat (8) tick();
        check_eq("br next pc", pop_pc_at(2), 32'h100);
        check_eq("br next data", pop_data_at(2), memf(32'h100));
        check_eq("br after pc", pop_pc_at(3), 32'h104);
        check_eq("br flush count", 32'(flush_cnt), 32'd1);

        // 4: funct3 / control sweep; taken shows up as a flush pulse
        for (int k = 0; k < 10; k++) begin
            v = vec[k];
            br_funct3 = v[7:5]; br_zf = v[4]; br_sf = v[3];
            br_branch = v[2]; br_jump = v[1]; br_valid = 1'b1;
            br_target = 32'h0000_0200;
            tick();
            br_valid = 1'b0; br_branch = 1'b0; br_jump = 1'b0; br_zf = 1'b0; br_sf = 1'b0;
            #1;
            check_eq($sformatf("sweep%0d taken", k), flush0, {31'd0, v[0]});
            repeat (4) tick();
        end
        check_eq("sweep misalign", mis0, 32'd0);

        // 5: misaligned jump halts until reset
        br_valid = 1'b1; br_jump = 1'b1; br_target = 32'h0000_0102;
        tick();
        br_valid = 1'b0; br_jump = 1'b0;
        #1;
        check_eq("mis err", mis0, 32'd1);
        check_eq("mis flush", flush0, 32'd1);
        n = req_log.size();
        repeat (6) tick();
        #1;
        check_eq("halt no req", 32'(req_log.size()), 32'(n));
        check_eq("halt req_valid", b0.imem_req_valid, 32'd0);
        check_eq("halt instr_valid", b0.instr_valid, 32'd0);
        check_eq("halt sticky", mis0, 32'd1);
        do_reset();
        #1;
        check_eq("rst clears err", mis0, 32'd0);
        check_eq("rst pc", b0.imem_addr, 32'h0);
        check_eq("rst resumes", b0.imem_req_valid, 32'd1);

        // 6: PC wrap from RESET_PC=0xFFFF_FFF8
        check_eq("wrap a0", req1_at(0), 32'hFFFF_FFF8);
        check_eq("wrap a1", req1_at(1), 32'hFFFF_FFFC);
        check_eq("wrap a2", req1_at(2), 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
